// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_access_pkg
// Summary  : Shared datapath widths, opcodes and FSM encodings for the
//            memory-access stage.
// Revision : 1.0
// ============================================================================
package mem_access_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
    localparam logic [RegBus-1:0]     ZeroWord   = '0;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [AluOpBus-1:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

endpackage
`default_nettype wire

// File: rtl/mem_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_fmt
// Summary  : Combinational opcode decode, big-endian byte-lane select, store
//            replication and load extraction/extension.
// Revision : 1.0
// ============================================================================
module mem_lane_fmt
    import mem_access_pkg::*;
(
    input  logic [AluOpBus-1:0] aluop_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [RegBus-1:0]   reg2_i,
    input  logic [RegBus-1:0]   rdata_i,
    output logic                is_mem_o,
    output logic                is_load_o,
    output logic                misalign_o,
    output logic [3:0]          sel_o,
    output logic [RegBus-1:0]   wdata_o,
    output logic [RegBus-1:0]   ldata_o
);

    mem_size_e   w_size;
    logic        w_sext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        is_mem_o  = 1'b1;
        is_load_o = 1'b0;
        w_size    = SZ_WORD;
        w_sext    = 1'b0;
        case (aluop_i)
            EXE_LB_OP:  begin is_load_o = 1'b1; w_size = SZ_BYTE; w_sext = 1'b1; end
            EXE_LBU_OP: begin is_load_o = 1'b1; w_size = SZ_BYTE; end
            EXE_LH_OP:  begin is_load_o = 1'b1; w_size = SZ_HALF; w_sext = 1'b1; end
            EXE_LHU_OP: begin is_load_o = 1'b1; w_size = SZ_HALF; end
            EXE_LW_OP:  begin is_load_o = 1'b1; w_size = SZ_WORD; end
            EXE_SB_OP:  w_size = SZ_BYTE;
            EXE_SH_OP:  w_size = SZ_HALF;
            EXE_SW_OP:  w_size = SZ_WORD;
            default:    is_mem_o = 1'b0;
        endcase
    end

    // Lane 0 (address offset 0) is the most significant byte of the word.
    always_comb begin
        case (addr_lo_i)
            2'd0:    w_byte = rdata_i[31:24];
            2'd1:    w_byte = rdata_i[23:16];
            2'd2:    w_byte = rdata_i[15:8];
            default: w_byte = rdata_i[7:0];
        endcase
        w_half = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    end

    always_comb begin
        misalign_o = 1'b0;
        sel_o      = 4'b1111;
        wdata_o    = reg2_i;
        ldata_o    = rdata_i;
        case (w_size)
            SZ_BYTE: begin
                sel_o   = 4'b1000 >> addr_lo_i;
                wdata_o = {4{reg2_i[7:0]}};
                ldata_o = w_sext ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            end
            SZ_HALF: begin
                misalign_o = is_mem_o & addr_lo_i[0];
                sel_o      = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                wdata_o    = {2{reg2_i[15:0]}};
                ldata_o    = w_sext ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            end
            default: begin
                misalign_o = is_mem_o & (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Summary  : MEM pipeline stage; pass-through for ALU ops, req/ack data-bus
//            transaction with stall request for loads and stores.
// Revision : 1.0
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [RegBus-1:0]     wdata_i,
    input  logic [AluOpBus-1:0]   aluop_i,
    input  logic [RegBus-1:0]     mem_addr_i,
    input  logic [RegBus-1:0]     reg2_i,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o,
    output logic                  stallreq,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [RegBus-1:0]     bus_addr,
    output logic [3:0]            bus_sel,
    output logic [RegBus-1:0]     bus_wdata,
    input  logic [RegBus-1:0]     bus_rdata,
    input  logic                  bus_ack,
    output logic                  misalign_o,
    output logic                  bus_err_o
);

    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [RegBus-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [RegBus-1:0] bus_wdata_q, bus_wdata_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [RegBus-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              w_is_mem;
    logic              w_is_load;
    logic              w_misalign;
    logic [3:0]        w_sel;
    logic [RegBus-1:0] w_st_data;
    logic [RegBus-1:0] w_ld_data;
    logic              w_unused;

    assign w_unused = ^{stall[5], stall[3:0]};

    mem_lane_fmt u_lane_fmt (
        .aluop_i    (aluop_i),
        .addr_lo_i  (mem_addr_i[1:0]),
        .reg2_i     (reg2_i),
        .rdata_i    (bus_rdata),
        .is_mem_o   (w_is_mem),
        .is_load_o  (w_is_load),
        .misalign_o (w_misalign),
        .sel_o      (w_sel),
        .wdata_o    (w_st_data),
        .ldata_o    (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= ZeroWord;
            bus_sel_q   <= 4'b0000;
            bus_wdata_q <= ZeroWord;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= ZeroWord;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stallreq    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_is_mem) begin
                    wreg_o = WriteDisable;
                    if (w_misalign) begin
                        misalign_d = 1'b1;
                    end else begin
                        stallreq    = 1'b1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = ~w_is_load;
                        bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                        bus_sel_d   = w_sel;
                        bus_wdata_d = w_st_data;
                        cnt_d       = '0;
                        err_d       = 1'b0;
                        state_d     = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stallreq = 1'b1;
                wreg_o   = WriteDisable;
                // Ack is checked first so it wins over a coincident timeout.
                if (bus_ack) begin
                    rdata_d   = w_ld_data;
                    bus_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == c_to_last)) begin
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_DONE: begin
                if (w_is_load) begin
                    wdata_o = rdata_q;
                    wreg_o  = wreg_i & ~err_q;
                end
                // Holding here while MEM is frozen keeps the op from re-issuing.
                if (!stall[4]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rst == RstEnable) begin
            wd_o     = NOPRegAddr;
            wreg_o   = WriteDisable;
            wdata_o  = ZeroWord;
            stallreq = 1'b0;
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_sel    = bus_sel_q;
    assign bus_wdata  = bus_wdata_q;
    assign misalign_o = misalign_q;
    assign bus_err_o  = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Summary  : Self-checking bench for mem_access against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        misalign_o;
    logic        bus_err_o;

    int n_checks = 0;
    int n_err    = 0;

    mem_access #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .aluop_i    (aluop_i),
        .mem_addr_i (mem_addr_i),
        .reg2_i     (reg2_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq   (stallreq),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_sel    (bus_sel),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .misalign_o (misalign_o),
        .bus_err_o  (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: access width in bytes, big-endian lane offset, replication and extension.
    task automatic ref_model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                             input logic [31:0] rdata, output bit is_mem, output bit is_load,
                             output bit is_mis, output logic [3:0] sel, output logic [31:0] wdat,
                             output logic [31:0] ldat);
        int nb;
        int off;
        bit sgn;
        longint unsigned mask;
        longint unsigned v;
        is_mem = 1; is_load = 0; is_mis = 0; nb = 4; sgn = 0;
        sel = 4'd0; wdat = 32'd0; ldat = 32'd0;
        case (op)
            EXE_LB_OP:  begin nb = 1; sgn = 1; is_load = 1; end
            EXE_LBU_OP: begin nb = 1; is_load = 1; end
            EXE_LH_OP:  begin nb = 2; sgn = 1; is_load = 1; end
            EXE_LHU_OP: begin nb = 2; is_load = 1; end
            EXE_LW_OP:  begin nb = 4; is_load = 1; end
            EXE_SB_OP:  nb = 1;
            EXE_SH_OP:  nb = 2;
            EXE_SW_OP:  nb = 4;
            default:    is_mem = 0;
        endcase
        off = int'(addr % 4);
        if (is_mem) is_mis = (off % nb) != 0;
        if (is_mem && !is_mis) begin
            mask = (64'd1 << (8 * nb)) - 64'd1;
            sel  = 4'(((1 << nb) - 1) << (4 - off - nb));
            for (int i = 0; i < 4 / nb; i++)
                wdat = wdat | 32'(({32'd0, reg2} & mask) << (8 * nb * i));
            v = ({32'd0, rdata} >> (8 * (4 - off - nb))) & mask;
            if (sgn && v[8 * nb - 1]) v = v | ~mask;
            ldat = 32'(v);
        end
    endtask

    task automatic mem_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [31:0] rdata, input int ack_at, input int hold);
        bit m_mem, m_load, m_mis, fin, to;
        logic [3:0]  e_sel;
        logic [31:0] e_wd, e_ld;
        int busy;
        ref_model(op, addr, reg2, rdata, m_mem, m_load, m_mis, e_sel, e_wd, e_ld);
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
        wd_i = 5'($urandom); wreg_i = 1'b1; wdata_i = $urandom;
        stall = 6'd0; bus_ack = 1'b0;
        @(negedge clk);
        if (!m_mem) begin
            check_val("pass_wdata", wdata_o, wdata_i);
            check_val("pass_wd", 32'(wd_o), 32'(wd_i));
            check_val("pass_wreg", 32'(wreg_o), 32'd1);
            check_val("pass_stall", 32'(stallreq), 32'd0);
            tick;
            check_val("pass_noreq", 32'(bus_req), 32'd0);
            return;
        end
        if (m_mis) begin
            check_val("mis_stall", 32'(stallreq), 32'd0);
            check_val("mis_wreg", 32'(wreg_o), 32'd0);
            tick;
            check_val("mis_pulse", 32'(misalign_o), 32'd1);
            check_val("mis_noreq", 32'(bus_req), 32'd0);
            return;
        end
        check_val("issue_stall", 32'(stallreq), 32'd1);
        tick;
        check_val("issue_req", 32'(bus_req), 32'd1);
        check_val("issue_addr", bus_addr, addr & 32'hFFFF_FFFC);
        check_val("issue_sel", 32'(bus_sel), 32'(e_sel));
        check_val("issue_we", 32'(bus_we), m_load ? 32'd0 : 32'd1);
        if (!m_load) check_val("issue_wdata", bus_wdata, e_wd);
        busy = 0; fin = 0; to = 0;
        while (!fin) begin
            busy++;
            if (busy == ack_at) begin bus_ack = 1'b1; bus_rdata = rdata; end
            @(negedge clk);
            check_val("busy_stall", 32'(stallreq), 32'd1);
            check_val("busy_req", 32'(bus_req), 32'd1);
            check_val("busy_sel", 32'(bus_sel), 32'(e_sel));
            if (busy == ack_at) fin = 1;
            else if (busy >= TO) begin fin = 1; to = 1; end
            tick;
            bus_ack = 1'b0; bus_rdata = $urandom;
        end
        check_val("done_req", 32'(bus_req), 32'd0);
        check_val("done_err", 32'(bus_err_o), 32'(to));
        @(negedge clk);
        check_val("done_stall", 32'(stallreq), 32'd0);
        check_val("done_wd", 32'(wd_o), 32'(wd_i));
        if (m_load) begin
            check_val("done_wreg", 32'(wreg_o), to ? 32'd0 : 32'd1);
            if (!to) check_val("done_ldata", wdata_o, e_ld);
        end else begin
            check_val("done_wreg", 32'(wreg_o), 32'd1);
            check_val("done_wdata", wdata_o, wdata_i);
        end
        for (int h = 0; h < hold; h++) begin
            // A stray ack while parked must be ignored.
            stall = 6'b011111; bus_ack = 1'b1; bus_rdata = ~rdata;
            tick;
            bus_ack = 1'b0;
            check_val("hold_noreq", 32'(bus_req), 32'd0);
            check_val("hold_err", 32'(bus_err_o), 32'd0);
            @(negedge clk);
            check_val("hold_stall", 32'(stallreq), 32'd0);
            if (m_load && !to) check_val("hold_ldata", wdata_o, e_ld);
        end
        stall = 6'd0;
        tick;
    endtask

    logic [7:0] ops [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ops[0] = EXE_LB_OP; ops[1] = EXE_LBU_OP; ops[2] = EXE_LH_OP;
        ops[3] = EXE_LHU_OP; ops[4] = EXE_LW_OP; ops[5] = EXE_SB_OP;
        ops[6] = EXE_SH_OP; ops[7] = EXE_SW_OP; ops[8] = EXE_ADD_OP;

        rst = 1'b1; stall = 6'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        aluop_i = EXE_ADD_OP; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1234_5678;
        mem_addr_i = 32'd0; reg2_i = 32'd0;
        tick; tick;
        @(negedge clk);
        check_val("rst_wd", 32'(wd_o), 32'd0);
        check_val("rst_wreg", 32'(wreg_o), 32'd0);
        check_val("rst_wdata", wdata_o, 32'd0);
        check_val("rst_stall", 32'(stallreq), 32'd0);
        check_val("rst_req", 32'(bus_req), 32'd0);
        check_val("rst_we", 32'(bus_we), 32'd0);
        check_val("rst_addr", bus_addr, 32'd0);
        check_val("rst_sel", 32'(bus_sel), 32'd0);
        check_val("rst_bwdata", bus_wdata, 32'd0);
        check_val("rst_mis", 32'(misalign_o), 32'd0);
        check_val("rst_err", 32'(bus_err_o), 32'd0);
        rst = 1'b0;
        tick;

        mem_txn(EXE_ADD_OP, 32'h0, 32'h0, 32'h0, 1, 0);
        mem_txn(EXE_LB_OP,  32'h1003, 32'h0, 32'hAABB_CC80, 3, 0);
        mem_txn(EXE_LBU_OP, 32'h1003, 32'h0, 32'hAABB_CC80, 3, 0);
        mem_txn(EXE_SH_OP,  32'h2002, 32'hDEAD_BEEF, 32'h0, 2, 0);
        mem_txn(EXE_LW_OP,  32'h3001, 32'h0, 32'h0, 1, 0);
        mem_txn(EXE_LH_OP,  32'h3003, 32'h0, 32'h0, 1, 0);
        mem_txn(EXE_LW_OP,  32'h4000, 32'h0, 32'h1111_2222, 0, 1);
        mem_txn(EXE_LW_OP,  32'h4004, 32'h0, 32'h5566_7788, TO, 0);
        mem_txn(EXE_LH_OP,  32'h4006, 32'h0, 32'h1234_8001, 1, 0);

        // Reset while the bus cycle is outstanding.
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h5000; wreg_i = 1'b1; wdata_i = 32'hCAFE_0001;
        tick;
        check_val("rstmid_req_up", 32'(bus_req), 32'd1);
        tick;
        rst = 1'b1;
        @(negedge clk);
        check_val("rstmid_stall", 32'(stallreq), 32'd0);
        check_val("rstmid_wreg", 32'(wreg_o), 32'd0);
        check_val("rstmid_wdata", wdata_o, 32'd0);
        tick;
        check_val("rstmid_req", 32'(bus_req), 32'd0);
        rst = 1'b0;
        mem_txn(EXE_LW_OP, 32'h5000, 32'h0, 32'h0BAD_F00D, 2, 0);
        mem_txn(EXE_SW_OP, 32'h6000, 32'h0123_4567, 32'h0, 1, 3);

        for (int n = 0; n < 40; n++) begin
            mem_txn(ops[$urandom_range(0, 8)], $urandom, $urandom, $urandom,
                    int'($urandom_range(0, TO + 2)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
